mul_fu_arbiter: RTL and testbench

- Shares one combinational 16x16 Wallace-tree multiplier between NUM_REQ issue ports of the scoreboard.
- Arbitrates round-robin and latches the operands for the multiplier's multicycle path.
- Captures the product and presents it with its destination tag on a valid/ready writeback handshake.
- Sits between the scoreboard issue logic and the result/writeback bus. The multiplier is instantiated outside this block and wired to the mul_* ports.

---
 rtl/mul_arb_pkg.sv | 17 +
 rtl/mul_fu_arbiter_rr_arbiter.sv | 36 +++
 rtl/mul_fu_arbiter.sv | 138 +++++++++++++
 tb/tb_mul_fu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier functional-unit arbiter.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OPW   = 16;
    localparam int PRODW = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_fu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic          found_s;
    logic [IW-1:0] pos_s;

    // Scan ports starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        pos_s     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (enable && !found_s && req[pos_s]) begin
                grant[pos_s] = 1'b1;
                grant_idx    = pos_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mul_fu_arbiter.sv
// Shares one external 16x16 multiplier between NUM_REQ issue ports and
// returns the product with its tag on a valid/ready writeback handshake.
module mul_fu_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TAG_W      = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*OPW-1:0]     req_a,
    input  logic [NUM_REQ*OPW-1:0]     req_b,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [OPW-1:0]             mul_a,
    output logic [OPW-1:0]             mul_b,
    input  logic [PRODW:0]             mul_p,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [PRODW-1:0]           res_data,
    output logic [TAG_W-1:0]           res_tag,
    output logic [$clog2(NUM_REQ)-1:0] res_src,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [IW-1:0] rr_ptr_r;

    logic               win_s;
    logic               accept_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IW-1:0]      grant_idx_s;
    logic [IW-1:0]      next_ptr_s;
    logic               unused_s;

    // Bit 32 of the product is always zero for unsigned 16x16.
    assign unused_s = mul_p[PRODW];

    // Grants are gated by reset so nothing is offered while held in reset.
    assign win_s = rst_n && !flush &&
                   ((state_r == IDLE) || ((state_r == DONE) && res_ready));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .enable    (win_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign req_ready = grant_s;
    assign accept_s  = |grant_s;

    // Pointer moves to the port after the one just granted.
    always_comb begin
        if (grant_idx_s == IW'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + IW'(1);
        end
    end

    // Control FSM; an accept in IDLE or DONE always restarts BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            rr_ptr_r  <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            res_data  <= '0;
            res_tag   <= '0;
            res_src   <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept_s) begin
            mul_a     <= req_a[OPW*grant_idx_s +: OPW];
            mul_b     <= req_b[OPW*grant_idx_s +: OPW];
            res_tag   <= req_tag[TAG_W*grant_idx_s +: TAG_W];
            res_src   <= grant_idx_s;
            rr_ptr_r  <= next_ptr_s;
            cnt_r     <= CW'(MUL_CYCLES - 1);
            state_r   <= BUSY;
            res_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r   <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                BUSY: begin
                    if (flush) begin
                        state_r   <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt_r == CW'(0)) begin
                        res_data  <= mul_p[PRODW-1:0];
                        state_r   <= DONE;
                        res_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        cnt_r     <= cnt_r - CW'(1);
                        state_r   <= BUSY;
                        res_valid <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DONE: begin
                    // Flush or a completed handshake without a new accept.
                    if (flush || res_ready) begin
                        state_r   <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        state_r   <= DONE;
                        res_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_fu_arbiter.sv
// Scoreboard bench for mul_fu_arbiter with directed, hand-computed vectors.
module tb_mul_fu_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int TAG_W      = 4;
    localparam int MUL_CYCLES = 3;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*16-1:0]    req_a;
    logic [NUM_REQ*16-1:0]    req_b;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [15:0]              mul_a;
    logic [15:0]              mul_b;
    logic [32:0]              mul_p;
    logic                     res_valid;
    logic                     res_ready;
    logic [31:0]              res_data;
    logic [TAG_W-1:0]         res_tag;
    logic [1:0]               res_src;
    logic                     busy;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic [1:0]  s;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   gcyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mul_fu_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_src   (res_src),
        .busy      (busy)
    );

    // Behavioural stand-in for the external multiplier.
    assign mul_p = 33'(mul_a) * 33'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: legality of grants, grant log, and scoreboard pops on handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_legal",
                64'(((req_ready & ~req_valid) == 4'b0000) && $onehot0(req_ready)), 64'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    glog.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
            if (res_valid && res_ready && !flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got data %h tag %h src %0d, expected none",
                             res_data, res_tag, res_src);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_data", 64'(res_data), 64'(e.d));
                    chk("res_tag",  64'(res_tag),  64'(e.t));
                    chk("res_src",  64'(res_src),  64'(e.s));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t);
        req_valid[p]        = 1'b1;
        req_a[p*16 +: 16]   = a;
        req_b[p*16 +: 16]   = b;
        req_tag[p*4 +: 4]   = t;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] t, input logic [1:0] s);
        exp_t e;
        e.d = d;
        e.t = t;
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic wait_accept(input int p, input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[p]) ok = 1'b1;
            else next_cycle();
        end
        chk(nm, 64'(ok), 64'd1);
    endtask

    task automatic wait_res(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (res_valid) ok = 1'b1;
            else next_cycle();
        end
        chk(nm, 64'(ok), 64'd1);
    endtask

    task automatic drain(input string nm);
        bit ok = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            next_cycle();
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        chk(nm, 64'(ok), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; res_ready = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op from port 1: result 4 cycles after accept.
        next_cycle();
        drive(1, 16'h00FF, 16'h0101, 4'd5);
        push(32'h0000FFFF, 4'd5, 2'd1);
        @(negedge clk);
        chk("t1_grant", 64'(req_ready), 64'h2);
        next_cycle();
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) next_cycle();
            res_ready = (k == 4);
            @(negedge clk);
            chk("t1_busy", 64'(busy), 64'd1);
            chk("t1_res_valid", 64'(res_valid), 64'(k == 4));
            chk("t1_mul_a", 64'(mul_a), 64'h00FF);
            chk("t1_mul_b", 64'(mul_b), 64'h0101);
        end
        next_cycle();
        res_ready = 1'b0;
        @(negedge clk);
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_valid", 64'(res_valid), 64'd0);

        // Backpressure on 0xFFFF*0xFFFF with port 0 waiting behind it.
        next_cycle();
        drive(2, 16'hFFFF, 16'hFFFF, 4'd7);
        push(32'hFFFE0001, 4'd7, 2'd2);
        @(negedge clk);
        chk("t3_grant", 64'(req_ready), 64'h4);
        next_cycle();
        req_valid = '0;
        drive(0, 16'h0002, 16'h0003, 4'd1);
        push(32'h00000006, 4'd1, 2'd0);
        wait_res("t3_res_wait");
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                next_cycle();
                @(negedge clk);
            end
            chk("t3_hold_data", 64'(res_data), 64'hFFFE0001);
            chk("t3_hold_ready", 64'(req_ready), 64'h0);
            chk("t3_hold_valid", 64'(res_valid), 64'd1);
        end
        next_cycle();
        res_ready = 1'b1;
        @(negedge clk);
        chk("t3_b2b_grant", 64'(req_ready), 64'h1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("t3_b2b_busy", 64'(busy), 64'd1);
        chk("t3_b2b_valid", 64'(res_valid), 64'd0);
        drain("t3_drain");

        // Flush in BUSY at cnt=1; pointer must stay past port 1.
        next_cycle();
        drive(1, 16'h0100, 16'h0100, 4'd9);
        @(negedge clk);
        chk("t4_grant", 64'(req_ready), 64'h2);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("t4_busy", 64'(busy), 64'd1);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("t4_flush_valid", 64'(res_valid), 64'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("t4_idle_busy", 64'(busy), 64'd0);
        chk("t4_idle_valid", 64'(res_valid), 64'd0);
        next_cycle();
        drive(1, 16'h0003, 16'h0007, 4'hE);
        drive(2, 16'h0011, 16'h0011, 4'h2);
        push(32'h00000121, 4'h2, 2'd2);
        push(32'h00000015, 4'hE, 2'd1);
        @(negedge clk);
        chk("t4_rr_kept", 64'(req_ready), 64'h4);
        next_cycle();
        req_valid[2] = 1'b0;
        wait_accept(1, "t4_port1_regrant");
        next_cycle();
        req_valid = '0;
        drain("t4_drain");

        // Flush together with res_ready in DONE.
        res_ready = 1'b0;
        next_cycle();
        drive(0, 16'h0040, 16'h0040, 4'd3);
        @(negedge clk);
        chk("t5_grant", 64'(req_ready), 64'h1);
        next_cycle();
        req_valid = '0;
        drive(3, 16'h0002, 16'h0002, 4'd4);
        push(32'h00000004, 4'd4, 2'd3);
        wait_res("t5_res_wait");
        next_cycle();
        flush = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("t5_no_accept", 64'(req_ready), 64'h0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_valid_low", 64'(res_valid), 64'd0);
        chk("t5_idle_grant", 64'(req_ready), 64'h8);
        next_cycle();
        req_valid = '0;
        drain("t5_drain");

        // Async reset mid-BUSY, then round-robin order from port 0.
        next_cycle();
        drive(0, 16'h0003, 16'h0005, 4'hA);
        drive(1, 16'h1234, 16'h0010, 4'hB);
        drive(2, 16'h8000, 16'h0002, 4'hC);
        drive(3, 16'hFFFF, 16'h0001, 4'hD);
        @(negedge clk);
        chk("t6_any_grant", 64'(|req_ready), 64'd1);
        next_cycle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_valid", 64'(res_valid), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'h0);
        chk("t6_rst_mul_a", 64'(mul_a), 64'h0);
        chk("t6_rst_tag", 64'(res_tag), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        glog.delete();
        gcyc.delete();
        push(32'h0000000F, 4'hA, 2'd0);
        push(32'h00012340, 4'hB, 2'd1);
        push(32'h00010000, 4'hC, 2'd2);
        push(32'h0000FFFF, 4'hD, 2'd3);
        push(32'h0000000F, 4'hA, 2'd0);
        for (int k = 0; k < 40 && glog.size() < 5; k++) begin
            @(negedge clk);
            #1;
            if (glog.size() < 5) next_cycle();
        end
        next_cycle();
        req_valid = '0;
        chk("t2_grant_count", 64'(glog.size()), 64'd5);
        for (int i = 0; i < 5 && i < glog.size(); i++) begin
            chk("t2_grant_order", 64'(glog[i]), 64'(i % 4));
            if (i > 0) chk("t2_grant_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd4);
        end
        drain("t2_drain");
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
